// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID opcode and stages the control bundle through ID/EX,
// EX/MEM and MEM/WB, with load-use stall, branch flush, external freeze and halt drain.
module ctrl_pipe #(
  parameter int unsigned REG_W       = 4,
  parameter bit          R0_WR_BLOCK = 1'b0,
  parameter bit          LU_STALL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             id_stall,
  output logic [2:0]       ex_aluop,
  output logic             ex_alusrc,
  output logic             ex_shift,
  output logic             ex_modify,
  output logic             ex_mem,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_read,
  output logic             mem_write,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_rd,
  output logic             halted
);

  localparam logic [3:0] OpLw  = 4'b1000;
  localparam logic [3:0] OpSw  = 4'b1001;
  localparam logic [3:0] OpLlb = 4'b1010;
  localparam logic [3:0] OpLhb = 4'b1011;
  localparam logic [3:0] OpPcs = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  typedef struct packed {
    logic [2:0]       aluop;
    logic             alusrc;
    logic             shift;
    logic             modify;
    logic             mem;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             memtoreg;
    logic             halt;
    logic [REG_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             memtoreg;
    logic             halt;
    logic [REG_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic             halt;
    logic [REG_W-1:0] rd;
  } wb_ctrl_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e    state_q, state_d;
  logic      ex_valid_q, ex_valid_d;
  logic      mem_valid_q, mem_valid_d;
  logic      wb_valid_q, wb_valid_d;
  ex_ctrl_t  ex_q, ex_d, dec;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;

  logic             advance;
  logic             load_id;
  logic             use_src1;
  logic             use_src2;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             hazard;

  always_comb begin
    dec       = '0;
    dec.rd    = id_rd;
    dec.aluop = id_opcode[2:0];
    case (id_opcode)
      OpLw: begin
        dec.aluop    = 3'b000;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.mem      = 1'b1;
        dec.regwrite = 1'b1;
      end
      OpSw: begin
        dec.aluop    = 3'b000;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.mem      = 1'b1;
      end
      OpLlb, OpLhb: begin
        dec.modify   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OpPcs:   dec.regwrite = 1'b1;
      OpHlt:   dec.halt = 1'b1;
      default: begin
        // Arithmetic group; 0100-0110 take an immediate shift amount. B/BR fall through with no flags.
        if (!id_opcode[3]) begin
          dec.regwrite = 1'b1;
          dec.shift    = id_opcode[2] & ~(id_opcode[1] & id_opcode[0]);
        end
      end
    endcase
    if (R0_WR_BLOCK && (id_rd == '0)) begin
      dec.regwrite = 1'b0;
    end
  end

  // Source slots actually read by the ID instruction; unused slots must not raise a hazard.
  always_comb begin
    use_src1 = !id_opcode[3] || (id_opcode[3:2] == 2'b10);
    use_src2 = (!id_opcode[3] && (!id_opcode[2] || (id_opcode[1:0] == 2'b11)))
               || (id_opcode == OpSw);
    src1     = dec.modify ? id_rd : id_rs;
    src2     = dec.mem ? id_rd : id_rt;
    hazard   = (use_src1 && (src1 == ex_q.rd)) || (use_src2 && (src2 == ex_q.rd));
  end

  assign id_stall = LU_STALL_EN && id_valid && ex_valid_q && ex_q.memread && ex_q.regwrite
                    && hazard;

  assign advance = !ext_stall;
  assign load_id = id_valid && (state_q == StRun) && !flush && !id_stall;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_d        = ex_q;
    mem_valid_d = mem_valid_q;
    mem_d       = mem_q;
    wb_valid_d  = wb_valid_q;
    wb_d        = wb_q;
    if (advance) begin
      ex_valid_d  = load_id;
      ex_d        = load_id ? dec : '0;
      mem_valid_d = ex_valid_q;
      mem_d       = '{memread:  ex_q.memread,
                      memwrite: ex_q.memwrite,
                      regwrite: ex_q.regwrite,
                      memtoreg: ex_q.memtoreg,
                      halt:     ex_q.halt,
                      rd:       ex_q.rd};
      wb_valid_d  = mem_valid_q;
      wb_d        = '{regwrite: mem_q.regwrite,
                      memtoreg: mem_q.memtoreg,
                      halt:     mem_q.halt,
                      rd:       mem_q.rd};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (advance && load_id && dec.halt) state_d = StDrain;
      StDrain:  if (advance && mem_valid_q && mem_q.halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      mem_valid_q <= mem_valid_d;
      mem_q       <= mem_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
    end
  end

  always_comb begin
    ex_aluop    = ex_valid_q ? ex_q.aluop : 3'b000;
    ex_alusrc   = ex_valid_q && ex_q.alusrc;
    ex_shift    = ex_valid_q && ex_q.shift;
    ex_modify   = ex_valid_q && ex_q.modify;
    ex_mem      = ex_valid_q && ex_q.mem;
    ex_rd       = ex_valid_q ? ex_q.rd : '0;
    mem_read    = mem_valid_q && mem_q.memread;
    mem_write   = mem_valid_q && mem_q.memwrite;
    mem_rd      = mem_valid_q ? mem_q.rd : '0;
    wb_regwrite = wb_valid_q && wb_q.regwrite;
    wb_memtoreg = wb_valid_q && wb_q.memtoreg;
    wb_rd       = wb_valid_q ? wb_q.rd : '0;
  end

  assign halted = (state_q == StHalted);

  // Once draining or halted, only bubbles may enter ID/EX.
  a_no_issue_after_hlt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StRun && !ext_stall) |=> !ex_valid_q);

  a_mem_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized and directed bench for ctrl_pipe against a stage-slot reference model.
module tb_ctrl_pipe;
  localparam int unsigned RW  = 4;
  localparam bit          R0B = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_opcode = '0;
  logic [RW-1:0] id_rd = '0, id_rs = '0, id_rt = '0;
  logic          flush = 1'b0, ext_stall = 1'b0;
  logic          id_stall;
  logic [2:0]    ex_aluop;
  logic          ex_alusrc, ex_shift, ex_modify, ex_mem;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic          mem_read, mem_write, wb_regwrite, wb_memtoreg, halted;

  ctrl_pipe #(.REG_W(RW), .R0_WR_BLOCK(R0B), .LU_STALL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .ext_stall(ext_stall), .id_stall(id_stall),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_shift(ex_shift), .ex_modify(ex_modify),
    .ex_mem(ex_mem), .ex_rd(ex_rd), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic valid; logic [2:0] aluop;
    logic alusrc, shift, modify, mem, memread, memwrite, regwrite, memtoreg, halt;
    logic [RW-1:0] rd;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  bit    m_drain, m_halted;
  int    n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t decode(input logic [3:0] op, input logic [RW-1:0] rd);
    slot_t s;
    s          = '0;
    s.valid    = 1'b1;
    s.rd       = rd;
    s.aluop    = (op == 4'd8 || op == 4'd9) ? 3'b000 : op[2:0];
    s.memread  = (op == 4'd8);
    s.memtoreg = (op == 4'd8);
    s.memwrite = (op == 4'd9);
    s.alusrc   = (op == 4'd8 || op == 4'd9);
    s.mem      = (op == 4'd8 || op == 4'd9);
    s.modify   = (op == 4'd10 || op == 4'd11);
    s.shift    = (op == 4'd4 || op == 4'd5 || op == 4'd6);
    s.halt     = (op == 4'd15);
    s.regwrite = (op < 4'd9 || op == 4'd10 || op == 4'd11 || op == 4'd14)
                 && !(R0B && rd == '0);
    return s;
  endfunction

  function automatic bit model_stall();
    bit u1, u2;
    logic [RW-1:0] s1, s2;
    if (!(id_valid && m_ex.valid && m_ex.memread && m_ex.regwrite)) return 1'b0;
    u1 = (id_opcode <= 4'd11);
    u2 = id_opcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9};
    s1 = (id_opcode inside {4'd10, 4'd11}) ? id_rd : id_rs;
    s2 = (id_opcode inside {4'd8, 4'd9}) ? id_rd : id_rt;
    return (u1 && s1 == m_ex.rd) || (u2 && s2 == m_ex.rd);
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_drain = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step();
    slot_t nx;
    if (!ext_stall) begin
      nx = '0;
      if (id_valid && !m_drain && !m_halted && !flush && !model_stall())
        nx = decode(id_opcode, id_rd);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nx;
      if (nx.halt) m_drain = 1'b1;
      if (m_wb.valid && m_wb.halt) m_halted = 1'b1;
    end
  endtask

  task automatic check_all();
    check("id_stall", id_stall, model_stall());
    check("ex_aluop", ex_aluop, m_ex.aluop);
    check("ex_alusrc", ex_alusrc, m_ex.alusrc);
    check("ex_shift", ex_shift, m_ex.shift);
    check("ex_modify", ex_modify, m_ex.modify);
    check("ex_mem", ex_mem, m_ex.mem);
    check("ex_rd", ex_rd, m_ex.rd);
    check("mem_read", mem_read, m_mem.memread);
    check("mem_write", mem_write, m_mem.memwrite);
    check("mem_rd", mem_rd, m_mem.rd);
    check("wb_regwrite", wb_regwrite, m_wb.regwrite);
    check("wb_memtoreg", wb_memtoreg, m_wb.memtoreg);
    check("wb_rd", wb_rd, m_wb.rd);
    check("halted", halted, m_halted);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs, input logic [RW-1:0] rt, input bit fl,
                       input bit es);
    id_valid = v; id_opcode = op; id_rd = rd; id_rs = rs; id_rt = rt;
    flush = fl; ext_stall = es;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit            r_v, r_fl, r_es, hold;
  logic [3:0]    r_op;
  logic [RW-1:0] r_rd, r_rs, r_rt;

  initial begin
    // ADD r3 then SUB: aluop sequence and write-back three cycles later
    do_reset();
    drive(1, 4'd0, 3, 1, 2, 0, 0); tick();
    check("t1_add_aluop", ex_aluop, 3'b000); check("t1_add_rd", ex_rd, 3);
    drive(1, 4'd1, 4, 1, 2, 0, 0); tick();
    check("t1_sub_aluop", ex_aluop, 3'b001);
    idle(); tick();
    check("t1_wb_we", wb_regwrite, 1); check("t1_wb_rd", wb_rd, 3);

    // LW r5 then ADD r6,r5,r1: one stall cycle, one bubble
    do_reset();
    drive(1, 4'd8, 5, 1, 0, 0, 0); tick();
    drive(1, 4'd0, 6, 5, 1, 0, 0); #1 check("t2_stall_on", id_stall, 1); tick();
    check("t2_mem_read", mem_read, 1); check("t2_ex_bubble_rd", ex_rd, 0);
    drive(1, 4'd0, 6, 5, 1, 0, 0); #1 check("t2_stall_off", id_stall, 0); tick();
    check("t2_mem_bubble", mem_read, 0); check("t2_wb_load", wb_memtoreg, 1);
    idle(); tick(); tick();
    check("t2_add_wb_rd", wb_rd, 6); check("t2_add_wb_we", wb_regwrite, 1);

    // LW r5 then SW r5 stalls; LW r5 then SLL r7,r2,#3 does not
    do_reset();
    drive(1, 4'd8, 5, 1, 0, 0, 0); tick();
    drive(1, 4'd9, 5, 1, 2, 0, 0); #1 check("t3_sw_stall", id_stall, 1); tick();
    drive(1, 4'd9, 5, 1, 2, 0, 0); tick();
    check("t3_sw_ex_mem", ex_mem, 1);
    idle(); tick(); tick(); tick();
    drive(1, 4'd8, 5, 1, 0, 0, 0); tick();
    drive(1, 4'd4, 7, 2, 3, 0, 0); #1 check("t3_sll_nostall", id_stall, 0); tick();
    check("t3_sll_shift", ex_shift, 1);

    // ext_stall freezes everything, flush alongside it is ignored
    do_reset();
    drive(1, 4'd8, 5, 1, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'd0, 6, 1, 2, 1, 1); tick();
      check("t4_frz_alusrc", ex_alusrc, 1); check("t4_frz_rd", ex_rd, 5);
    end
    drive(1, 4'd0, 6, 1, 2, 0, 0); tick();
    check("t4_rel_rd", ex_rd, 6); check("t4_rel_mem_read", mem_read, 1);

    // flush squashes LLB in ID; older ADD still retires
    do_reset();
    drive(1, 4'd0, 3, 1, 2, 0, 0); tick();
    drive(1, 4'd10, 4, 0, 0, 1, 0); tick();
    check("t5_modify", ex_modify, 0); check("t5_rd", ex_rd, 0); check("t5_mem_rd", mem_rd, 3);
    idle(); tick();
    check("t5_wb_add_rd", wb_rd, 3); check("t5_wb_add_we", wb_regwrite, 1);
    tick();
    check("t5_no_llb_write", wb_regwrite, 0);

    // HLT drains the pipe; following ADD never issues; r0 write blocked
    do_reset();
    drive(1, 4'd15, 0, 0, 0, 0, 0); tick();
    drive(1, 4'd0, 2, 1, 1, 0, 0); tick();
    check("t6_add_blocked", ex_rd, 0); check("t6_not_halted", halted, 0);
    tick();
    check("t6_halted", halted, 1);
    idle(); tick(); tick();
    check("t6_halt_sticky", halted, 1); check("t6_no_write", wb_regwrite, 0);
    do_reset();
    check("t6_reset_clears_halt", halted, 0);
    drive(1, 4'd0, 0, 1, 2, 0, 0); tick();
    idle(); tick(); tick();
    check("t6_r0_block", wb_regwrite, 0);

    // Randomized traffic with occasional mid-cycle resets
    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        hold = 1'b0;
        continue;
      end
      if (!hold) begin
        r_v  = ($urandom_range(0, 4) != 0);
        r_op = 4'($urandom_range(0, 15));
        if (r_op == 4'd15 && $urandom_range(0, 9) != 0) r_op = 4'd8;
        r_rd = RW'($urandom_range(0, 3));
        r_rs = RW'($urandom_range(0, 3));
        r_rt = RW'($urandom_range(0, 3));
      end
      r_fl = ($urandom_range(0, 7) == 0);
      r_es = ($urandom_range(0, 7) == 0);
      drive(r_v, r_op, r_rd, r_rs, r_rt, r_fl, r_es);
      hold = r_es || model_stall();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
